// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator on the 100 MHz system clock.
// Advances one pixel per enable pulse and produces registered hsync/vsync,
// video_on, pixel coordinates and line/frame start pulses.
// Optional build macro VGA_INTERNAL_CE_EN: when defined, an internal 2-bit
// phase counter produces the pixel enable (every 4th clock) and the pix_ce
// port is ignored; when undefined, pix_ce is the only advance source.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int CNT_W       = 10
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic             adv;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             wrap_x;

`ifdef VGA_INTERNAL_CE_EN
  logic [1:0] phase;
  logic       unused_pix_ce;

  assign unused_pix_ce = pix_ce;

  // Free-running divide-by-4 phase; the enable fires on the last phase.
  always_ff @(posedge clk_100MHz) begin
    if (rst) phase <= 2'd0;
    else     phase <= phase + 2'd1;
  end

  assign adv = (phase == 2'd3);
`else
  assign adv = pix_ce;
`endif

  assign wrap_x = (pix_x == H_LAST);

  // Next raster position; outputs are derived from it so they need no extra cycle.
  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (adv) begin
      if (wrap_x) begin
        x_nxt = '0;
        y_nxt = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
      end else begin
        x_nxt = pix_x + 1'b1;
      end
    end
  end

  // Counter and output registers; reset parks the raster on the last pixel of the frame.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pix_x       <= H_LAST;
      pix_y       <= V_LAST;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= x_nxt;
      pix_y       <= y_nxt;
      hsync       <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on    <= (x_nxt < H_VIS_END) && (y_nxt < V_VIS_END);
      line_start  <= adv && wrap_x;
      frame_start <= adv && wrap_x && (pix_y == V_LAST);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Drives a full-size instance and a tiny-raster instance (15x8, active-high
// syncs) from the same rst/pix_ce so whole frames, vsync and frame wrap are
// exercised in a short run. Expected outputs come from hand-written raster
// rules with literal constants, queued per clock and popped by a monitor.
module tb_vga_timing_gen;

  logic       clk_100MHz;
  logic       rst;
  logic       pix_ce;

  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pix_x, pix_y;
  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_pix_x, s_pix_y;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       shs;
    logic       svs;
    logic       svon;
    logic       sls;
    logic       sfs;
  } exp_t;

  exp_t exp_q[$];

  int checks_total;
  int checks_passed;
  int fail_prints;

  int mx, my, sx, sy;
  int m_phase;

`ifdef VGA_INTERNAL_CE_EN
  localparam int HOLD_Y = 5;
`else
  localparam int HOLD_Y = 50;
`endif

  vga_timing_gen dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE(1'b1), .CNT_W(10)
  ) dut_small (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .video_on   (s_video_on),
    .pix_x      (s_pix_x),
    .pix_y      (s_pix_y),
    .line_start (s_line_start),
    .frame_start(s_frame_start)
  );

  // 100 MHz clock
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // Drive one clock of inputs and queue the outputs expected after that edge
  task automatic applyStimulus(input logic r, input logic ce);
    logic adv;
    logic ls, fs, sls, sfs;
    exp_t e;
    @(negedge clk_100MHz);
    rst    = r;
    pix_ce = ce;
`ifdef VGA_INTERNAL_CE_EN
    adv = !r && (m_phase == 3);
    m_phase = r ? 0 : (m_phase + 1) % 4;
`else
    adv = !r && ce;
`endif
    ls = 1'b0; fs = 1'b0; sls = 1'b0; sfs = 1'b0;
    if (r) begin
      mx = 799; my = 524;
      sx = 14;  sy = 7;
    end else if (adv) begin
      if (mx == 799) begin
        ls = 1'b1;
        fs = (my == 524);
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      if (sx == 14) begin
        sls = 1'b1;
        sfs = (sy == 7);
        sx = 0;
        sy = (sy == 7) ? 0 : sy + 1;
      end else begin
        sx = sx + 1;
      end
    end
    e.x    = 10'(mx);
    e.y    = 10'(my);
    e.hs   = !((mx >= 656) && (mx < 752));
    e.vs   = !((my >= 490) && (my < 492));
    e.von  = (mx < 640) && (my < 480);
    e.ls   = ls;
    e.fs   = fs;
    e.sx   = 10'(sx);
    e.sy   = 10'(sy);
    e.shs  = (sx >= 10) && (sx < 13);
    e.svs  = (sy >= 5) && (sy < 7);
    e.svon = (sx < 8) && (sy < 4);
    e.sls  = sls;
    e.sfs  = sfs;
    exp_q.push_back(e);
  endtask

  // Compare one queued expectation against the sampled DUT outputs
  task automatic checkOutput(input exp_t e);
    exp_t a;
    a.x = pix_x; a.y = pix_y; a.hs = hsync; a.vs = vsync; a.von = video_on;
    a.ls = line_start; a.fs = frame_start;
    a.sx = s_pix_x; a.sy = s_pix_y; a.shs = s_hsync; a.svs = s_vsync;
    a.svon = s_video_on; a.sls = s_line_start; a.sfs = s_frame_start;
    checks_total++;
    if (a === e) begin
      checks_passed++;
    end else if (fail_prints < 20) begin
      fail_prints++;
      $display("[TB] FAIL raster @%0t: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b | sx=%0d sy=%0d hs=%b vs=%b von=%b ls=%b fs=%b ; want x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b | sx=%0d sy=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
               $time, a.x, a.y, a.hs, a.vs, a.von, a.ls, a.fs, a.sx, a.sy, a.shs, a.svs, a.svon, a.sls, a.sfs,
               e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs, e.sx, e.sy, e.shs, e.svs, e.svon, e.sls, e.sfs);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 ns after the rising edge
  initial begin
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  // Advance with pix_ce high until the full-size model reaches (tx, ty)
  task automatic runTo(input int tx, input int ty);
    int guard;
    guard = 0;
    while (!(mx == tx && my == ty) && guard < 60000) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 60000) begin
      checks_total++;
      $display("[TB] FAIL runTo budget: got (%0d,%0d) want (%0d,%0d)", mx, my, tx, ty);
    end
  endtask

  // Directed sequence
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    fail_prints   = 0;
    m_phase = 0;
    mx = 799; my = 524; sx = 14; sy = 7;
    rst    = 1'b1;
    pix_ce = 1'b0;

    $display("[TB] reset and first pixel");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, (i % 4) == 3);

    $display("[TB] one full line with pix_ce held high");
    for (int i = 0; i < 810; i++) applyStimulus(1'b0, 1'b1);

    $display("[TB] hold pix_ce low mid-frame");
    runTo(100, HOLD_Y);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    runTo(300, HOLD_Y);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, (i % 4) == 3);

    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    checks_total++;
    if (exp_q.size() == 0) checks_passed++;
    else $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
